// File: rtl/regfile_stack_ctrl.sv
// Interrupt/mret context controller that drives the stacked register file command.
// Optional TAIL_CHAIN_EN: retarget the top context instead of pop+push. o_command: 0=none, 1=push, 2=pop.
module regfile_stack_ctrl #(
  parameter int DEPTH  = 4,
  parameter int PRIO_W = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_irq_valid,
  input  logic [PRIO_W-1:0]        i_irq_prio,
  input  logic                     i_mret,
  input  logic                     i_stall,
  output logic [1:0]               o_command,
  output logic                     o_irq_ack,
  output logic [$clog2(DEPTH)-1:0] o_depth,
  output logic [PRIO_W-1:0]        o_cur_prio,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int DW = $clog2(DEPTH);
  localparam logic [DW-1:0] MAXD = DW'(DEPTH - 1);

  localparam logic [1:0] Command_none = 2'd0;
  localparam logic [1:0] Command_push = 2'd1;
  localparam logic [1:0] Command_pop  = 2'd2;

  typedef enum logic {IDLE, CMD} state_t;

  state_t              r_state;
  logic [1:0]          r_cmd;
  logic                r_ack;
  logic [DW-1:0]       r_depth;
  logic [PRIO_W-1:0]   r_prio;
  logic                r_ovf;
  logic                r_unf;
  logic [PRIO_W-1:0]   r_stack [DEPTH];

  state_t              w_state_n;
  logic [1:0]          w_cmd_n;
  logic                w_ack_n;
  logic [DW-1:0]       w_depth_n;
  logic [PRIO_W-1:0]   w_prio_n;
  logic                w_ovf_n;
  logic                w_unf_n;
  logic                w_we;
  logic [DW-1:0]       w_idx;
  logic [PRIO_W-1:0]   w_below;
  logic                w_hit;

  // Entry 0 is the base context and is never written, so it stays 0.
  assign w_below = r_stack[r_depth - 1'b1];
  assign w_hit   = i_irq_valid && (i_irq_prio > r_prio);

  always_comb begin
    w_state_n = r_state;
    w_cmd_n   = Command_none;
    w_ack_n   = 1'b0;
    w_depth_n = r_depth;
    w_prio_n  = r_prio;
    w_ovf_n   = r_ovf;
    w_unf_n   = r_unf;
    w_we      = 1'b0;
    w_idx     = r_depth + 1'b1;
    unique case (r_state)
      IDLE: begin
        if (!i_stall) begin
          if (i_mret && r_depth != '0) begin
`ifdef TAIL_CHAIN_EN
            if (i_irq_valid && i_irq_prio > w_below) begin
              w_state_n = CMD;
              w_ack_n   = 1'b1;
              w_we      = 1'b1;
              w_idx     = r_depth;
              w_prio_n  = i_irq_prio;
            end else
`endif
            begin
              w_state_n = CMD;
              w_cmd_n   = Command_pop;
              w_depth_n = r_depth - 1'b1;
              w_prio_n  = w_below;
            end
          end else if (i_mret) begin
            w_unf_n = 1'b1;
          end else if (w_hit && r_depth != MAXD) begin
            w_state_n = CMD;
            w_cmd_n   = Command_push;
            w_ack_n   = 1'b1;
            w_we      = 1'b1;
            w_depth_n = r_depth + 1'b1;
            w_prio_n  = i_irq_prio;
          end else if (w_hit) begin
            w_ovf_n = 1'b1;
          end
        end
      end
      CMD: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cmd   <= Command_none;
      r_ack   <= 1'b0;
      r_depth <= '0;
      r_prio  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_state <= w_state_n;
      r_cmd   <= w_cmd_n;
      r_ack   <= w_ack_n;
      r_depth <= w_depth_n;
      r_prio  <= w_prio_n;
      r_ovf   <= w_ovf_n;
      r_unf   <= w_unf_n;
      if (w_we) r_stack[w_idx] <= i_irq_prio;
    end
  end

  assign o_command   = r_cmd;
  assign o_irq_ack   = r_ack;
  assign o_depth     = r_depth;
  assign o_cur_prio  = r_prio;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule

// File: tb/tb_regfile_stack_ctrl.sv
// Directed table-driven bench for regfile_stack_ctrl (DEPTH=4, PRIO_W=3).
// Rows are one cycle each: inputs driven, then outputs checked #1 after the edge.
module tb_regfile_stack_ctrl;

  localparam logic [1:0] CN = 2'd0;
  localparam logic [1:0] CP = 2'd1;
  localparam logic [1:0] CO = 2'd2;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_irq_valid = 1'b0;
  logic [2:0] i_irq_prio = '0;
  logic       i_mret = 1'b0;
  logic       i_stall = 1'b0;
  logic [1:0] o_command;
  logic       o_irq_ack;
  logic [1:0] o_depth;
  logic [2:0] o_cur_prio;
  logic       o_overflow;
  logic       o_underflow;

  regfile_stack_ctrl #(.DEPTH(4), .PRIO_W(3)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_irq_valid(i_irq_valid), .i_irq_prio(i_irq_prio),
    .i_mret(i_mret), .i_stall(i_stall),
    .o_command(o_command), .o_irq_ack(o_irq_ack),
    .o_depth(o_depth), .o_cur_prio(o_cur_prio),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [2:0] ip;
    logic       mr;
    logic       st;
    logic [9:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [9:0] pk(logic [1:0] c, logic a, logic [1:0] d,
                                    logic [2:0] p, logic ov, logic un);
    return {c, a, d, p, ov, un};
  endfunction

  task automatic add(logic rst, logic iv, logic [2:0] ip, logic mr,
                     logic st, logic [9:0] e);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ip = ip; v.mr = mr; v.st = st; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic drive(logic rst, logic iv, logic [2:0] ip, logic mr, logic st);
    i_reset = rst; i_irq_valid = iv; i_irq_prio = ip;
    i_mret = mr; i_stall = st;
  endtask

  task automatic check(string name, logic [9:0] e);
    logic [9:0] a;
    a = {o_command, o_irq_ack, o_depth, o_cur_prio, o_overflow, o_underflow};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got cmd/ack/depth/prio/ovf/unf=%b required %b",
               name, a, e);
    end
  endtask

  task automatic step(string name, logic rst, logic iv, logic [2:0] ip,
                      logic mr, logic st, logic [9:0] e);
    drive(rst, iv, ip, mr, st);
    @(posedge i_clk); #1;
    check(name, e);
  endtask

  initial begin
    add(1, 0, 0, 0, 0, pk(CN, 0, 0, 0, 0, 0));
    add(0, 1, 3, 0, 0, pk(CP, 1, 1, 3, 0, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 1, 3, 0, 0));
    for (int i = 0; i < 5; i++) add(0, 1, 2, 0, 0, pk(CN, 0, 1, 3, 0, 0));
    add(0, 1, 2, 1, 0, pk(CO, 0, 0, 0, 0, 0));
    add(0, 1, 2, 0, 0, pk(CN, 0, 0, 0, 0, 0));
    add(0, 1, 2, 0, 0, pk(CP, 1, 1, 2, 0, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 1, 2, 0, 0));
    add(0, 0, 0, 1, 0, pk(CO, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, 0, pk(CP, 1, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 1, 1, 0, 0));
    add(0, 1, 2, 0, 0, pk(CP, 1, 2, 2, 0, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 2, 2, 0, 0));
    add(0, 1, 3, 0, 0, pk(CP, 1, 3, 3, 0, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 3, 3, 0, 0));
    add(0, 1, 5, 0, 0, pk(CN, 0, 3, 3, 1, 0));
    add(0, 1, 5, 0, 0, pk(CN, 0, 3, 3, 1, 0));
    add(0, 0, 0, 1, 0, pk(CO, 0, 2, 2, 1, 0));
    add(0, 0, 0, 1, 0, pk(CN, 0, 2, 2, 1, 0));
    add(0, 0, 0, 1, 0, pk(CO, 0, 1, 1, 1, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 1, 1, 1, 0));
    add(0, 0, 0, 1, 0, pk(CO, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(CN, 0, 0, 0, 1, 0));
    add(0, 0, 0, 1, 0, pk(CN, 0, 0, 0, 1, 1));
    add(0, 1, 4, 0, 1, pk(CN, 0, 0, 0, 1, 1));
    add(0, 1, 4, 0, 1, pk(CN, 0, 0, 0, 1, 1));
    add(0, 1, 4, 0, 0, pk(CP, 1, 1, 4, 1, 1));
    add(0, 0, 0, 0, 0, pk(CN, 0, 1, 4, 1, 1));

    #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].iv, vq[i].ip, vq[i].mr, vq[i].st);
      @(posedge i_clk); #1;
      check($sformatf("vec%0d", i), vq[i].exp);
    end

`ifdef TAIL_CHAIN_EN
    step("tc_mret_irq", 0, 1, 6, 1, 0, pk(CN, 1, 1, 6, 1, 1));
    step("tc_cmd",      0, 1, 6, 0, 0, pk(CN, 0, 1, 6, 1, 1));
    step("tc_masked",   0, 1, 6, 0, 0, pk(CN, 0, 1, 6, 1, 1));
`else
    step("sim_pop",     0, 1, 6, 1, 0, pk(CO, 0, 0, 0, 1, 1));
    step("sim_cmd",     0, 1, 6, 0, 0, pk(CN, 0, 0, 0, 1, 1));
    step("sim_push",    0, 1, 6, 0, 0, pk(CP, 1, 1, 6, 1, 1));
`endif
    step("idle6", 0, 0, 0, 0, 0, pk(CN, 0, 1, 6, 1, 1));

    step("push7", 0, 1, 7, 0, 0, pk(CP, 1, 2, 7, 1, 1));
    #2;
    i_reset = 1'b1;
    #1;
    check("async_rst", pk(CN, 0, 0, 0, 0, 0));
    step("rst_hold", 1, 0, 0, 0, 0, pk(CN, 0, 0, 0, 0, 0));
    step("post_rst", 0, 1, 1, 0, 0, pk(CP, 1, 1, 1, 0, 0));
    step("post_cmd", 0, 0, 0, 0, 0, pk(CN, 0, 1, 1, 0, 0));
    step("post_pop", 0, 0, 0, 1, 0, pk(CO, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
